// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA framebuffer scheduler: NES geometry,
// fetch FSM states, the read tag carried through the RAM latency, and {y,x} packing.
package vga_fb_pkg;
  localparam int NES_W    = 256;
  localparam int NES_H    = 240;
  localparam int PIX_W    = 6;
  localparam int H_OFFSET = 64;
  localparam int FX_W     = $clog2(NES_W);
  localparam logic [PIX_W-1:0] BORDER_INDEX = 6'h0F;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

  typedef struct packed {
    logic            bank;
    logic [FX_W-1:0] fx;
  } rd_tag_t;

  function automatic logic [15:0] fb_pack(input logic [7:0] y, input logic [7:0] x);
    return {y, x};
  endfunction
endpackage

// File: rtl/mod_vga_fb_scheduler_line_buffer.sv
// Ping-pong scanline store: two banks of NES_W palette indices, one write port
// fed by returning framebuffer reads, one registered read port for the VGA side.
module mod_vga_line_buffer
  import vga_fb_pkg::*;
(
  input  logic             in_clk_25_175_mhz,
  input  logic             in_reset,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [FX_W-1:0]  wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [FX_W-1:0]  rd_addr,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] mem [2*NES_W];

  always_ff @(posedge in_clk_25_175_mhz)
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;

  always_ff @(posedge in_clk_25_175_mhz or posedge in_reset)
    if (in_reset) rd_data <= '0;
    else          rd_data <= mem[{rd_bank, rd_addr}];
endmodule

// File: rtl/mod_vga_fb_scheduler.sv
// Shares the single-port NES framebuffer between PPU writes and scanline prefetch,
// then streams 2x-scaled centred pixels. Optional scanline dim: MOD_VGA_FB_SCANLINE_EN.
module mod_vga_fb_scheduler
  import vga_fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             in_clk_25_175_mhz,
  input  logic             in_reset,
  input  logic             in_vga_frame_start,
  input  logic             in_vga_line_start,
  input  logic [9:0]       in_vga_next_x,
  input  logic             in_vga_active,
  input  logic             in_ppu_wr_valid,
  input  logic [7:0]       in_ppu_wr_x,
  input  logic [7:0]       in_ppu_wr_y,
  input  logic [PIX_W-1:0] in_ppu_wr_data,
  output logic             out_ppu_wr_ready,
  output logic [15:0]      out_fb_addr,
  output logic             out_fb_we,
  output logic [PIX_W-1:0] out_fb_wdata,
  input  logic [PIX_W-1:0] in_fb_rdata,
  output logic [PIX_W-1:0] out_pix_index,
  output logic             out_pix_dim,
  output logic             out_underrun
);
  fetch_state_t     state;
  logic [FX_W-1:0]  fx;
  logic [7:0]       fetch_y;
  logic [8:0]       vline;
  logic             front_bank, fetch_done, last_grant;
  logic [RD_LAT:0]  vld_pipe;
  rd_tag_t          tag_pipe [RD_LAT:0];

  // Even VGA lines start a new NES line; frame_start overrides line_start.
  logic even_ls, abort, kick, rd_req, ppu_gnt, rd_gnt;
  assign even_ls = in_vga_line_start & ~in_vga_frame_start & ~vline[0];
  assign abort   = in_vga_frame_start | even_ls;
  assign kick    = in_vga_frame_start |
                   (even_ls & (({1'b0, vline[8:1]} + 9'd1) < 9'(NES_H)));
  assign rd_req  = (state == FETCH) & ~abort;
  // last_grant = 1 when the fetcher won last; the other side wins a tie next.
  assign ppu_gnt = in_ppu_wr_valid & (~rd_req | last_grant);
  assign rd_gnt  = rd_req & ~ppu_gnt;
  assign out_ppu_wr_ready = ppu_gnt;

  always_ff @(posedge in_clk_25_175_mhz or posedge in_reset) begin
    if (in_reset) begin
      state        <= IDLE;
      fx           <= '0;
      fetch_y      <= '0;
      vline        <= '0;
      front_bank   <= 1'b0;
      fetch_done   <= 1'b0;
      last_grant   <= 1'b0;
      out_underrun <= 1'b0;
      out_fb_we    <= 1'b0;
      out_fb_addr  <= '0;
      out_fb_wdata <= '0;
    end else begin
      if (ppu_gnt | rd_gnt) last_grant <= rd_gnt;
      if (ppu_gnt && in_ppu_wr_y < 8'(NES_H)) begin
        out_fb_we    <= 1'b1;
        out_fb_addr  <= fb_pack(in_ppu_wr_y, in_ppu_wr_x);
        out_fb_wdata <= in_ppu_wr_data;
      end else begin
        out_fb_we <= 1'b0;
        if (rd_gnt) out_fb_addr <= fb_pack(fetch_y, 8'(fx));
      end

      if (in_vga_frame_start) vline <= '0;
      else if (in_vga_line_start) begin
        if (!vline[0]) begin
          if (!fetch_done) out_underrun <= 1'b1;
          front_bank <= ~front_bank;
        end
        if (vline != 9'd479) vline <= vline + 9'd1;
      end

      if (abort) fetch_done <= 1'b0;
      if (kick) begin
        state   <= FETCH;
        fx      <= '0;
        fetch_y <= in_vga_frame_start ? 8'd0 : vline[8:1] + 8'd1;
      end else if (abort) state <= IDLE;
      else begin
        case (state)
          FETCH: if (rd_gnt) begin
            fx <= fx + 1'b1;
            if (fx == FX_W'(NES_W-1)) state <= DRAIN;
          end
          DRAIN: if (~|vld_pipe[RD_LAT-1:0]) state <= DONE;
          DONE: begin
            fetch_done <= 1'b1;
            state      <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Read tags ride alongside the RAM latency; an abort discards everything in flight.
  always_ff @(posedge in_clk_25_175_mhz or posedge in_reset) begin
    if (in_reset) begin
      vld_pipe <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      vld_pipe    <= abort ? '0 : {vld_pipe[RD_LAT-1:0], rd_gnt};
      tag_pipe[0] <= '{bank: ~front_bank, fx: fx};
      for (int k = 1; k <= RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  logic            in_win, win_q;
  logic [FX_W-1:0] lb_raddr;
  logic [PIX_W-1:0] lb_rdata;
  assign in_win   = in_vga_active && in_vga_next_x >= 10'(H_OFFSET) &&
                    in_vga_next_x < 10'(H_OFFSET + 2*NES_W);
  assign lb_raddr = FX_W'((in_vga_next_x - 10'(H_OFFSET)) >> 1);

  mod_vga_line_buffer u_lb (
    .in_clk_25_175_mhz (in_clk_25_175_mhz),
    .in_reset          (in_reset),
    .wr_en             (vld_pipe[RD_LAT] & ~abort),
    .wr_bank           (tag_pipe[RD_LAT].bank),
    .wr_addr           (tag_pipe[RD_LAT].fx),
    .wr_data           (in_fb_rdata),
    .rd_bank           (front_bank),
    .rd_addr           (lb_raddr),
    .rd_data           (lb_rdata)
  );

  always_ff @(posedge in_clk_25_175_mhz or posedge in_reset)
    if (in_reset) win_q <= 1'b0;
    else          win_q <= in_win;

  assign out_pix_index = win_q ? lb_rdata : BORDER_INDEX;

`ifdef MOD_VGA_FB_SCANLINE_EN
  // Parity of the VGA line being shown, latched before vline advances.
  logic line_odd;
  always_ff @(posedge in_clk_25_175_mhz or posedge in_reset) begin
    if (in_reset) begin
      line_odd    <= 1'b0;
      out_pix_dim <= 1'b0;
    end else begin
      if (in_vga_frame_start)     line_odd <= 1'b0;
      else if (in_vga_line_start) line_odd <= vline[0];
      out_pix_dim <= in_win & line_odd;
    end
  end
`else
  assign out_pix_dim = 1'b0;
`endif
endmodule

// File: tb/tb_mod_vga_fb_scheduler.sv
// Directed bench for mod_vga_fb_scheduler with a 1-cycle synchronous framebuffer model.
module tb_mod_vga_fb_scheduler;
  localparam int RD_LAT = 1;
`ifdef MOD_VGA_FB_SCANLINE_EN
  localparam bit DIM_ON = 1'b1;
`else
  localparam bit DIM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, frame_start, line_start, active, ppu_valid;
  logic [9:0]  next_x;
  logic [7:0]  ppu_x, ppu_y;
  logic [5:0]  ppu_data, fb_wdata, fb_rdata, pix_index;
  logic [15:0] fb_addr;
  logic        ppu_ready, fb_we, pix_dim, underrun;

  bit [5:0] mem [65536];
  bit       wv  [65536];
  int n_chk = 0, n_pass = 0;
  int cyc, acc, alt_err, land_err;

  always #5 clk = ~clk;

  mod_vga_fb_scheduler #(.RD_LAT(RD_LAT)) dut (
    .in_clk_25_175_mhz  (clk),
    .in_reset           (rst),
    .in_vga_frame_start (frame_start),
    .in_vga_line_start  (line_start),
    .in_vga_next_x      (next_x),
    .in_vga_active      (active),
    .in_ppu_wr_valid    (ppu_valid),
    .in_ppu_wr_x        (ppu_x),
    .in_ppu_wr_y        (ppu_y),
    .in_ppu_wr_data     (ppu_data),
    .out_ppu_wr_ready   (ppu_ready),
    .out_fb_addr        (fb_addr),
    .out_fb_we          (fb_we),
    .out_fb_wdata       (fb_wdata),
    .in_fb_rdata        (fb_rdata),
    .out_pix_index      (pix_index),
    .out_pix_dim        (pix_dim),
    .out_underrun       (underrun)
  );

  // Preload pattern: index = (x + y)[5:0]; overridden by any write seen.
  function automatic logic [5:0] pre(input logic [15:0] a);
    logic [7:0] s;
    s = a[15:8] + a[7:0];
    return s[5:0];
  endfunction

  function automatic logic [5:0] ram_rd(input logic [15:0] a);
    return wv[a] ? mem[a] : pre(a);
  endfunction

  always @(posedge clk) begin
    if (fb_we) begin
      mem[fb_addr] <= fb_wdata;
      wv[fb_addr]  <= 1'b1;
    end
    fb_rdata <= ram_rd(fb_addr);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input bit fs, input bit ls);
    frame_start = fs; line_start = ls;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input bit act, input logic [5:0] exp);
    next_x = x; active = act;
    tick();
    chk(tag, pix_index, exp);
  endtask

  task automatic wait_done(input string tag, input int bound, output int n);
    n = 0;
    while (!dut.fetch_done && n < bound) begin tick(); n++; end
    chk(tag, dut.fetch_done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; frame_start = 0; line_start = 0; active = 0; next_x = '0;
    ppu_valid = 0; ppu_x = '0; ppu_y = '0; ppu_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_pix",     pix_index, 6'h0F);
    chk("rst_we",      fb_we, 0);
    chk("rst_addr",    fb_addr, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready",   ppu_ready, 0);
    chk("rst_dim",     pix_dim, 0);

    // Reset asserted asynchronously in the middle of a fetch.
    pulse(1, 0);
    repeat (100) tick();
    chk("pre_rst_fx",   dut.fx, 100);
    chk("pre_rst_addr", fb_addr, 99);
    #2 rst = 1'b1; #1;
    chk("midrst_addr", fb_addr, 0);
    chk("midrst_pix",  pix_index, 6'h0F);
    chk("midrst_fx",   dut.fx, 0);
    chk("midrst_state", dut.state, 0);
    chk("midrst_pipe", dut.vld_pipe, 0);
    tick();
    rst = 1'b0;
    tick();

    pulse(1, 0);
    tick(); chk("fetch_fx0", fb_addr, 16'h0000);
    tick(); chk("fetch_fx1", fb_addr, 16'h0001);
    wait_done("line0_done", 600, cyc);

    // VGA line 0 shows NES line 0.
    pulse(0, 1);
    pix("l0_x63",  10'd63,  1, 6'h0F);
    pix("l0_x64",  10'd64,  1, 6'h00);
    pix("l0_x65",  10'd65,  1, 6'h00);
    pix("l0_x66",  10'd66,  1, 6'h01);
    pix("l0_x575", 10'd575, 1, 6'h3F);
    pix("l0_x576", 10'd576, 1, 6'h0F);
    pix("l0_inact", 10'd100, 0, 6'h0F);
    pix("l0_x100", 10'd100, 1, 6'h12);
    chk("l0_dim", pix_dim, 0);
    chk("l0_underrun", underrun, 0);
    wait_done("line1_done", 600, cyc);

    pulse(0, 1);
    pix("l1_x100", 10'd100, 1, 6'h12);
    chk("l1_dim", pix_dim, DIM_ON);

    // VGA line 2 shows NES line 1 while line 2 is fetched against PPU traffic.
    pulse(0, 1);
    pix("l2_x100", 10'd100, 1, 6'h13);
    chk("l2_dim", pix_dim, 0);
    acc = 0; alt_err = 0;
    for (int k = 0; k < 500; k++) begin
      ppu_valid = 1'b1; ppu_x = acc[7:0]; ppu_y = 8'd200; ppu_data = acc[5:0] ^ 6'h2A;
      #3;
      if (ppu_ready !== ((k % 2) == 0)) alt_err++;
      if (ppu_ready) acc++;
      tick();
    end
    ppu_valid = 1'b0;
    wait_done("line2_done", 100, cyc);
    chk("fetch_time_ok", (501 + cyc) <= (2*256 + RD_LAT + 4), 1);
    chk("alt_errors", alt_err, 0);
    chk("ppu_accepted", acc, 250);
    land_err = 0;
    for (int i = 0; i < acc; i++) begin
      logic [7:0] ix;
      ix = 8'(i);
      if (ram_rd({8'd200, ix}) !== (ix[5:0] ^ 6'h2A)) land_err++;
    end
    chk("ppu_land_errors", land_err, 0);

    // Out-of-range row is accepted but dropped; in-range row writes through.
    ppu_valid = 1'b1; ppu_y = 8'd240; ppu_x = 8'd5; ppu_data = 6'h21;
    #3; chk("y240_ready", ppu_ready, 1);
    tick();
    chk("y240_we",   fb_we, 0);
    chk("y240_addr", fb_addr, 16'h02FF);
    ppu_y = 8'd10; ppu_x = 8'd7; ppu_data = 6'h15;
    tick();
    chk("y10_we",    fb_we, 1);
    chk("y10_addr",  fb_addr, 16'h0A07);
    chk("y10_wdata", fb_wdata, 6'h15);
    ppu_valid = 1'b0;
    tick(); tick();
    chk("y10_mem",  ram_rd(16'h0A07), 6'h15);
    chk("y240_mem", ram_rd(16'hF005), 6'h35);

    // Underrun: fetch of line 3 starved by the PPU, next even line_start 300 cycles on.
    pulse(0, 1);
    pulse(0, 1);
    chk("pre_underrun", underrun, 0);
    for (int k = 0; k < 300; k++) begin
      ppu_valid = 1'b1; ppu_y = 8'd200; ppu_x = 8'(k); ppu_data = 6'h00;
      line_start = (k == 150);
      tick();
    end
    line_start = 1'b1; tick(); line_start = 1'b0;
    ppu_valid = 1'b0;
    chk("underrun_set", underrun, 1);
    pix("ur_x64", 10'd64, 1, 6'h03);
    pix("ur_x66", 10'd66, 1, 6'h04);
    wait_done("line4_done", 600, cyc);
    pulse(0, 1);
    pulse(0, 1);
    chk("underrun_sticky", underrun, 1);

    pulse(1, 1);
    chk("fs_wins_vline", dut.vline, 0);
    chk("fs_wins_state", dut.state, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
